// File: rtl/fnv1a_frame_checker.sv
// Receive-side FNV-1a frame checker: hashes a payload byte stream, then compares
// the computed 32-bit hash against a 4-byte big-endian digest that follows it.
module fnv1a_frame_checker #(
  parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5,
  parameter logic [31:0] FNV_PRIME    = 32'h01000193
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic [31:0] hash_out,
  output logic [15:0] byte_count
);

  typedef enum logic [1:0] {StIdle, StPayload, StDigest, StReport} state_e;

  state_e      state_q, state_d;
  logic [31:0] hash_q, hash_d;
  logic [15:0] cnt_q, cnt_d;
  logic        match_q, match_d;
  logic [31:0] rx_q, rx_d;
  logic [1:0]  idx_q, idx_d;
  logic        accept;
  logic [31:0] rx_shift;

  // frame_start wins over a same-cycle byte, so the byte is never taken.
  assign accept   = in_valid && in_ready && !frame_start;
  assign rx_shift = {rx_q[23:0], in_data};

  // Next-state, hash update and digest capture.
  always_comb begin
    state_d = state_q;
    hash_d  = hash_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    rx_d    = rx_q;
    idx_d   = idx_q;
    if (frame_start) begin
      // Starts a new frame, or aborts the current one without a verdict.
      state_d = StPayload;
      hash_d  = OFFSET_BASIS;
      cnt_d   = '0;
      match_d = 1'b0;
      rx_d    = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        StIdle: ;
        StPayload: begin
          if (accept) begin
            // Constant multiplier; product truncated to 32 bits.
            hash_d = (hash_q ^ {24'b0, in_data}) * FNV_PRIME;
            cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            if (in_last) begin
              state_d = StDigest;
              idx_d   = '0;
            end
          end
        end
        StDigest: begin
          if (accept) begin
            rx_d  = rx_shift;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_d = StReport;
              // Verdict registered on the 4th byte so it is valid alongside done.
              match_d = (rx_shift == hash_q);
            end
          end
        end
        StReport: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      hash_q  <= OFFSET_BASIS;
      cnt_q   <= '0;
      match_q <= 1'b0;
      rx_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      hash_q  <= hash_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      rx_q    <= rx_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decoded from state and registers.
  always_comb begin
    busy       = (state_q == StPayload) || (state_q == StDigest);
    in_ready   = busy;
    done       = (state_q == StReport);
    match      = match_q;
    hash_out   = hash_q;
    byte_count = cnt_q;
  end

endmodule

// File: tb/tb_fnv1a_frame_checker.sv
// Directed bench for fnv1a_frame_checker.
module tb_fnv1a_frame_checker;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready, busy, done, match;
  logic [31:0] hash_out;
  logic [15:0] byte_count;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  fnv1a_frame_checker dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .busy       (busy),
    .done       (done),
    .match      (match),
    .hash_out   (hash_out),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fnv_model(input bq_t q);
    logic [31:0] h;
    h = 32'h811C9DC5;
    foreach (q[i]) h = (h ^ {24'b0, q[i]}) * 32'h01000193;
    return h;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last, input bit gap);
    int n;
    if (gap) repeat ($urandom_range(0, 2)) tick;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
    tick;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic start_frame(input bit with_valid);
    frame_start = 1'b1;
    if (with_valid) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
    end
    tick;
    frame_start = 1'b0;
    in_valid    = 1'b0;
    check("start_busy", {31'b0, busy}, 32'd1);
    check("start_ready", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run_frame(input string tag, input bq_t pl, input logic [31:0] dig,
                           input bit gap, input bit drop_test, input logic [31:0] exp_hash,
                           input logic [15:0] exp_cnt, input logic exp_match);
    int d0;
    start_frame(drop_test);
    d0 = done_cnt;
    for (int i = 0; i < pl.size(); i++) send_byte(pl[i], (i == pl.size() - 1), gap);
    check({tag, "_hash_pre"}, hash_out, exp_hash);
    for (int k = 0; k < 4; k++) send_byte(dig[31 - 8 * k -: 8], 1'b0, gap);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_match"}, {31'b0, match}, {31'b0, exp_match});
    check({tag, "_hash"}, hash_out, exp_hash);
    check({tag, "_count"}, {16'b0, byte_count}, {16'b0, exp_cnt});
    tick;
    check({tag, "_done_low"}, {31'b0, done}, 32'd0);
    check({tag, "_idle"}, {30'b0, busy, in_ready}, 32'd0);
    check({tag, "_match_hold"}, {31'b0, match}, {31'b0, exp_match});
    check({tag, "_done_once"}, done_cnt - d0, 32'd1);
  endtask

  initial begin
    bq_t a_q, foobar_q, foo_q, zero_q;
    int d_before;
    a_q      = '{8'h61};
    foobar_q = '{8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};
    foo_q    = '{8'h66, 8'h6F, 8'h6F};

    tick;
    tick;
    reset = 1'b0;
    check("rst_hash", hash_out, 32'h811C9DC5);
    check("rst_count", {16'b0, byte_count}, 32'd0);
    check("rst_flags", {28'b0, in_ready, busy, done, match}, 32'd0);

    run_frame("a", a_q, 32'hE40C292C, 1'b0, 1'b0, 32'hE40C292C, 16'd1, 1'b1);
    run_frame("foobar", foobar_q, 32'hBF9CF968, 1'b0, 1'b0, 32'hBF9CF968, 16'd6, 1'b1);
    run_frame("foobar_bad", foobar_q, 32'hBF9CF868, 1'b0, 1'b0, 32'hBF9CF968, 16'd6, 1'b0);
    run_frame("foobar_gap", foobar_q, 32'hBF9CF968, 1'b1, 1'b0, 32'hBF9CF968, 16'd6, 1'b1);

    // Offered bytes in IDLE must be ignored.
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    repeat (3) tick;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("idle_hash", hash_out, 32'hBF9CF968);
    check("idle_count", {16'b0, byte_count}, 32'd6);
    check("idle_busy", {31'b0, busy}, 32'd0);

    // Abort after 3 payload bytes; restart with a byte offered in the same cycle.
    d_before = done_cnt;
    start_frame(1'b0);
    foreach (foo_q[i]) send_byte(foo_q[i], 1'b0, 1'b0);
    check("abort_count_mid", {16'b0, byte_count}, 32'd3);
    run_frame("abort_a", a_q, 32'hE40C292C, 1'b0, 1'b1, 32'hE40C292C, 16'd1, 1'b1);
    check("abort_done_total", done_cnt - d_before, 32'd1);

    // Reset during DIGEST.
    start_frame(1'b0);
    send_byte(8'h61, 1'b1, 1'b0);
    send_byte(8'hE4, 1'b0, 1'b0);
    send_byte(8'h0C, 1'b0, 1'b0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("mid_rst_hash", hash_out, 32'h811C9DC5);
    check("mid_rst_count", {16'b0, byte_count}, 32'd0);
    check("mid_rst_flags", {28'b0, in_ready, busy, done, match}, 32'd0);
    run_frame("post_rst_a", a_q, 32'hE40C292C, 1'b0, 1'b0, 32'hE40C292C, 16'd1, 1'b1);

    // Long frame: byte_count saturates, hash keeps running.
    for (int i = 0; i < 70000; i++) zero_q.push_back(8'h00);
    run_frame("long", zero_q, fnv_model(zero_q), 1'b0, 1'b0, fnv_model(zero_q), 16'hFFFF, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fnv1a_frame_checker.md
# fnv1a_frame_checker

Receive-side integrity checker for byte-framed messages on the I2C peripheral datapath. It consumes a payload byte stream and computes the 32-bit FNV-1a hash octet by octet. It then accepts a 4-byte transmitted digest and reports whether the digest matches the computed hash. It is the consumer-end counterpart to the word-wide FNV-1a hash generator used on the send side.

## Interface
Parameters:
- OFFSET_BASIS, 32'h811C9DC5, initial hash value
- FNV_PRIME, 32'h01000193, multiplier

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  begin new frame; single-cycle pulse
- in_valid  in  1  in_data is offered this cycle
- in_data  in  8  payload or digest byte
- in_last  in  1  qualifies the final payload byte; ignored in DIGEST
- in_ready  out  1  byte accepted when in_valid & in_ready
- busy  out  1  frame in progress (PAYLOAD or DIGEST)
- done  out  1  one-cycle pulse, verdict available
- match  out  1  received digest == computed hash; valid from done, held
- hash_out  out  32  running or final computed hash
- byte_count  out  16  payload bytes hashed, saturates at 16'hFFFF

## Operation
- States: IDLE, PAYLOAD, DIGEST, REPORT.
- IDLE:
  - in_ready=0.
  - frame_start -> PAYLOAD.
  - On entry to PAYLOAD: hash=OFFSET_BASIS, byte_count=0, match=0, digest shift register=0.
- PAYLOAD, in_ready=1. On each accepted byte:
  - hash <= (hash ^ {24'b0, in_data}) * FNV_PRIME, truncated mod 2^32.
  - byte_count <= byte_count+1, saturating.
  - If in_last, next state is DIGEST with digest index=0.
- DIGEST, in_ready=1:
  - Accept exactly 4 bytes, MSB first: rx <= {rx[23:0], in_data}.
  - hash is frozen.
  - After the 4th byte, go to REPORT.
- REPORT, one cycle:
  - done=1, match <= (rx == hash), in_ready=0.
  - Then return to IDLE.
- Multiply: full 32x32 not required. FNV_PRIME = 2^24 + 2^8 + 8'h93, so the product = (h<<24) + (h<<8) + h*8'h93 mod 2^32. Any single-cycle implementation producing that result is acceptable.
- Zero-length payloads are not supported. The minimum frame is 1 payload byte plus 4 digest bytes.
- frame_start in any non-IDLE state aborts the current frame:
  - re-initialise as above and enter PAYLOAD;
  - no done pulse for the aborted frame.
- frame_start takes priority over a same-cycle in_valid; that byte is not accepted.
- in_valid while in_ready=0 is ignored, with no state change.
- busy = (state==PAYLOAD || state==DIGEST).

## Timing
- Reset values:
  - state=IDLE;
  - hash_out=OFFSET_BASIS;
  - byte_count=0;
  - in_ready=0, busy=0, done=0, match=0.
- reset overrides every other input in the same cycle, including mid-frame.
- frame_start in cycle N -> in_ready=1 and busy=1 in cycle N+1.
- hash_out and byte_count reflect a byte accepted in cycle N from cycle N+1.
- in_last byte accepted in cycle N -> DIGEST in N+1. The first digest byte can be accepted in N+1, for zero bubbles.
- 4th digest byte accepted in cycle M -> done=1 and match valid in M+1; IDLE in M+2.
- Sustained throughput: 1 byte per cycle. An L-byte frame completes in L+4 accepting cycles plus 1 REPORT cycle.
- match and hash_out hold after done until the next frame_start or reset.

## Test plan
- Payload "a" (8'h61) + digest E4,0C,29,2C -> hash_out=32'hE40C292C, byte_count=1, done pulse in the cycle after the last digest byte, match=1.
- Payload "foobar" back-to-back + digest BF,9C,F9,68 -> hash_out=32'hBF9CF968, byte_count=6, match=1. Repeat with digest byte 3 = 8'hF8 -> match=0, done still pulses once.
- in_valid gapped randomly (including during DIGEST) on the "foobar" frame -> identical result. No byte is accepted while in_ready=0, including in IDLE and REPORT.
- frame_start after 3 payload bytes, then "a" frame -> no done for the aborted frame, byte_count=1, match=1. Same-cycle frame_start+in_valid -> that byte is dropped.
- reset asserted during DIGEST -> next cycle all outputs at reset values and hash_out=32'h811C9DC5. A subsequent "a" frame passes.
- 70000-byte payload of 8'h00 -> byte_count saturates at 16'hFFFF. hash_out equals the software model; done and match follow the supplied digest.
